// File: rtl/seq_encoder_pkg.sv
// Shared types and widths for the sequential 8-to-3 request encoder.
package seq_encoder_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // One-hot mask selecting the request line named by a code.
  function automatic logic [REQ_W-1:0] code_mask(input logic [CODE_W-1:0] code);
    logic [REQ_W-1:0] one;
    one = REQ_W'(1);
    return one << code;
  endfunction

endpackage

// File: rtl/seq_encoder_8to3_prio.sv
// Combinational priority encoder for an 8-bit vector.
//   low_first = 1 : index of the lowest set bit
//   low_first = 0 : index of the highest set bit
//   only          : exactly one bit of vec is set
// An all-zero vector yields idx = 0, only = 0.
module prio_enc8
  import seq_encoder_pkg::*;
(
  input  logic [REQ_W-1:0]  vec,
  input  logic              low_first,
  output logic [CODE_W-1:0] idx,
  output logic              only
);

  // Scan so that the last match written is the winning bit.
  always_comb begin
    idx = '0;
    if (low_first) begin
      for (int i = REQ_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < REQ_W; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

  // A non-zero vector with its lowest set bit cleared is empty iff one bit was set.
  always_comb begin
    only = (vec != '0) && ((vec & (vec - REQ_W'(1))) == '0);
  end

endmodule

// File: rtl/seq_encoder_8to3.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of
// each set bit in priority order over a valid/ready handshake.
//
// Optional feature: define SEQ_ENCODER_OVERFLOW_EN to add a sticky `overflow`
// output flagging a non-empty load that arrived while busy.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no pending requests, waiting for req_load with req_in != 0
// EMIT  | pending non-empty, out_code presents the next line to serve
module seq_encoder_8to3
  import seq_encoder_pkg::*;
#(
  parameter int LOW_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  req_in,
  input  logic              req_load,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last
`ifdef SEQ_ENCODER_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  localparam logic LOW_DIR = (LOW_FIRST != 0);

  state_t             state;
  state_t             state_nxt;
  logic [REQ_W-1:0]   pending;
  logic [REQ_W-1:0]   pending_nxt;
  logic               load_ok;
  logic [CODE_W-1:0]  enc_idx;
  logic               enc_only;

  assign load_ok   = req_load && (req_in != '0);
  assign busy      = (state == EMIT);
  assign out_valid = busy;

  // Next pending set and state: capture in IDLE, retire the served bit on handshake.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (load_ok) begin
          pending_nxt = req_in;
          state_nxt   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_nxt = pending & ~code_mask(out_code);
          if (out_last) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  // Encoding is done on the next pending set so code/last can be registered
  // and appear together with the state they describe.
  prio_enc8 u_prio (
    .vec       (pending_nxt),
    .low_first (LOW_DIR),
    .idx       (enc_idx),
    .only      (enc_only)
  );

  // State, pending set and registered code/last; outputs are zero outside EMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      out_code <= '0;
      out_last <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (state_nxt == EMIT) begin
        out_code <= enc_idx;
        out_last <= enc_only;
      end else begin
        out_code <= '0;
        out_last <= 1'b0;
      end
    end
  end

`ifdef SEQ_ENCODER_OVERFLOW_EN
  // Sticky record of a dropped load; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (busy && load_ok) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule
